// File: rtl/lii_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lii_pkg
//  Description : Shared LII definitions. ID width, default packing width and
//                the output-arbiter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package lii_pkg;

  localparam int LII_ID_W       = 8;
  localparam int LII_PW_DEFAULT = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage : lii_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Returns the first asserted
//                request at or after ptr_i, wrapping modulo NREQ.
//  Ports       : req_i     - request vector
//                ptr_i     - starting index (must be < NREQ)
//                gnt_oh_o  - one-hot grant of the winner
//                gnt_idx_o - binary index of the winner
//                any_req_o - at least one request asserted
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_oh_o,
  output logic [PTR_W-1:0] gnt_idx_o,
  output logic             any_req_o
);

  always_comb begin
    int idx;
    idx       = 0;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_req_o = 1'b0;
    // Walk NREQ slots starting at ptr; the first hit wins.
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!any_req_o && req_i[idx]) begin
        any_req_o     = 1'b1;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = PTR_W'(idx);
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/lii_out_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lii_out_arbiter
//  Description : Shares one LII output channel between NREQ requester
//                streams. Round-robin grants with bursts capped at MAX_BURST
//                beats, feeding a registered output stage that stamps
//                src = SRC_ID and dst = the granted requester's destination.
//  Ports       : aclk, arstn          - clock, async active-low reset
//                req_tdata/tvalid/tready/dst - NREQ requester streams
//                lii_out_p0_*         - registered output channel
//                busy                 - GRANT state or output beat pending
//                stat_beats           - per-requester beat counters
//                                       (only with LII_ARB_STATS_EN)
//  Build macro : LII_ARB_STATS_EN - adds saturating per-requester beat
//                counters and the stat_beats port.
//  Revision    : 1.0 - initial release
// ============================================================================
module lii_out_arbiter
  import lii_pkg::*;
#(
  parameter int                  NREQ      = 2,
  parameter int                  PW        = LII_PW_DEFAULT,
  parameter int                  MAX_BURST = 16,
  parameter logic [LII_ID_W-1:0] SRC_ID    = 8'h00
) (
  input  logic                     aclk,
  input  logic                     arstn,
  input  logic [NREQ*PW-1:0]       req_tdata,
  input  logic [NREQ-1:0]          req_tvalid,
  output logic [NREQ-1:0]          req_tready,
  input  logic [NREQ*LII_ID_W-1:0] req_dst,
  output logic [PW-1:0]            lii_out_p0_tdata,
  output logic                     lii_out_p0_tvalid,
  input  logic                     lii_out_p0_tready,
  output logic [LII_ID_W-1:0]      lii_out_p0_src,
  output logic [LII_ID_W-1:0]      lii_out_p0_dst,
  output logic                     busy
`ifdef LII_ARB_STATS_EN
  ,
  output logic [NREQ*32-1:0]       stat_beats
`endif
);

  localparam int                 c_ptr_w     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int                 c_cnt_w     = $clog2(MAX_BURST + 1);
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(MAX_BURST - 1);

  arb_state_e           state_q;
  logic [c_ptr_w-1:0]   ptr_q;
  logic [c_ptr_w-1:0]   ptr_d;
  logic [c_ptr_w-1:0]   g_q;
  logic [NREQ-1:0]      gnt_oh_q;
  logic [c_cnt_w-1:0]   beat_cnt_q;
  logic [c_cnt_w-1:0]   beat_cnt_d;

  logic [PW-1:0]        tdata_q;
  logic                 tvalid_q;
  logic [LII_ID_W-1:0]  src_q;
  logic [LII_ID_W-1:0]  dst_q;

  logic [NREQ-1:0]      pick_oh;
  logic [c_ptr_w-1:0]   pick_idx;
  logic                 any_req;

  logic                 in_grant;
  logic                 can_load;
  logic                 grant_valid;
  logic                 xfer;
  logic                 burst_end;
  logic                 release_grant;
  logic [PW-1:0]        sel_tdata;
  logic [LII_ID_W-1:0]  sel_dst;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (c_ptr_w)
  ) u_rr_pick (
    .req_i     (req_tvalid),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .any_req_o (any_req)
  );

  // Mux the granted requester using the registered one-hot grant.
  always_comb begin
    sel_tdata   = '0;
    sel_dst     = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh_q[i]) begin
        sel_tdata   = req_tdata[i*PW +: PW];
        sel_dst     = req_dst[i*LII_ID_W +: LII_ID_W];
        grant_valid = req_tvalid[i];
      end
    end
  end

  assign in_grant      = (state_q == GRANT);
  assign can_load      = ~tvalid_q | lii_out_p0_tready;
  assign xfer          = in_grant & grant_valid & can_load;
  assign burst_end     = xfer & (beat_cnt_q == c_last_beat);
  // Stalls (grant_valid=1, can_load=0) neither count nor release.
  assign release_grant = in_grant & (~grant_valid | burst_end);
  assign req_tready    = (in_grant & can_load) ? gnt_oh_q : '0;

  assign beat_cnt_d = xfer ? (beat_cnt_q + 1'b1) : beat_cnt_q;

  // Next pointer is one past the releasing requester, so it is served last
  // if it re-requests immediately.
  always_comb begin
    if (int'(g_q) >= NREQ - 1) begin
      ptr_d = '0;
    end else begin
      ptr_d = g_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      g_q        <= '0;
      gnt_oh_q   <= '0;
      beat_cnt_q <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q    <= GRANT;
            g_q        <= pick_idx;
            gnt_oh_q   <= pick_oh;
            beat_cnt_q <= '0;
          end
        end
        GRANT: begin
          beat_cnt_q <= beat_cnt_d;
          if (release_grant) begin
            state_q <= IDLE;
            ptr_q   <= ptr_d;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      // A load wins over a same-cycle pop, keeping tvalid high.
      if (xfer) begin
        tdata_q  <= sel_tdata;
        dst_q    <= sel_dst;
        src_q    <= SRC_ID;
        tvalid_q <= 1'b1;
      end else if (lii_out_p0_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign lii_out_p0_tdata  = tdata_q;
  assign lii_out_p0_tvalid = tvalid_q;
  assign lii_out_p0_src    = src_q;
  assign lii_out_p0_dst    = dst_q;
  assign busy              = in_grant | tvalid_q;

`ifdef LII_ARB_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stats
    logic [31:0] cnt_q;
    always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
        cnt_q <= '0;
      end else if (xfer && gnt_oh_q[i] && (cnt_q != 32'hFFFF_FFFF)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign stat_beats[i*32 +: 32] = cnt_q;
  end
`endif

endmodule : lii_out_arbiter
`default_nettype wire

// File: doc/lii_out_arbiter.md
Name: lii_out_arbiter

Overview:
- Shares one LII physical output channel (lii_out_p0) between NREQ logical kernel output streams.
- Each requester presents a PW-wide beat and an 8-bit destination ID.
- Grants are round-robin, with bounded bursts.
- Drives a registered output stage that stamps src = SRC_ID and dst = the requester's dst.
- Sits between the per-kernel pack logic and the LII phy output of a stream wrapper.

Parameters:
- NREQ, 2, number of requester streams (>=1).
- PW, 64, packing width of LII tdata.
- MAX_BURST, 16, max beats per grant before forced rotation (>=1, need not be a power of 2).
- SRC_ID, 8'h00, value driven on lii_out_p0_src.

Ports:
- aclk  in  1  single clock; all state on rising edge.
- arstn  in  1  asynchronous active-low reset.
- req_tdata  in  NREQ*PW  requester beats; requester i at [i*PW +: PW].
- req_tvalid  in  NREQ  per-requester valid.
- req_tready  out  NREQ  per-requester ready.
- req_dst  in  NREQ*8  per-requester destination ID; sampled with each beat.
- lii_out_p0_tdata  out  PW  output beat.
- lii_out_p0_tvalid  out  1  output valid.
- lii_out_p0_tready  in  1  downstream ready.
- lii_out_p0_src  out  8  source ID.
- lii_out_p0_dst  out  8  destination ID of the current beat.
- busy  out  1  high when in GRANT or when lii_out_p0_tvalid=1. Use as kernel ce gating.

Behaviour:
- Reset, asynchronous on arstn low:
  - lii_out_p0_tvalid=0, tdata=0, src=0, dst=0.
  - req_tready all 0, busy=0.
  - State = IDLE, rr pointer = 0, beat_cnt = 0.
  - Any in-flight output beat is discarded.
- Output register and load enable:
  - can_load = ~lii_out_p0_tvalid | lii_out_p0_tready.
  - On a requester transfer, the register loads tdata, dst and src=SRC_ID, and sets tvalid=1.
  - Otherwise, if lii_out_p0_tready=1, tvalid clears.
  - While tvalid=1 and tready=0, tdata, src and dst stay stable.
- State IDLE:
  - All req_tready = 0.
  - If any req_tvalid is high, pick the first valid index at or after ptr (wrapping modulo NREQ).
  - Register that index as g, clear beat_cnt, and go to GRANT.
  - With no valid requester, stay in IDLE.
- State GRANT:
  - req_tready[g] = can_load; all other tready = 0.
  - A transfer occurs when req_tvalid[g] & req_tready[g]; each transfer increments beat_cnt.
  - Leave to IDLE and set ptr = (g+1) mod NREQ when either:
    - a transfer makes beat_cnt reach MAX_BURST, or
    - req_tvalid[g] = 0 in a cycle.
  - Backpressure stalls inside GRANT do not count as beats and do not trigger release.
- Latency and throughput:
  - req_tvalid first seen in IDLE at cycle t.
  - Grant at t+1; transfer at t+1 if can_load.
  - lii_out_p0_tvalid at t+2.
  - One beat per cycle inside a burst; one bubble cycle per grant change.
- Widths: beat_cnt is $clog2(MAX_BURST+1) bits; ptr and g are max(1,$clog2(NREQ)) bits.
- NREQ=1: ptr is fixed at 0 and the pointer logic degenerates. Bursts are still capped, so a bubble appears every MAX_BURST beats.
- Simultaneous events:
  - A release and a new request from the same requester in the same cycle: that requester may be regranted only after all other valid requesters, per round-robin order.
  - A downstream pop and a requester load in the same cycle: the load takes effect and tvalid stays 1.

Optional Feature:
- Macro: LII_ARB_STATS_EN.
- Defined:
  - Adds output port stat_beats, NREQ*32 bits.
  - One 32-bit saturating counter per requester, incremented on each of that requester's transfers.
  - Reset to 0; holds at 32'hFFFF_FFFF.
- Undefined: the port and the counters are absent; all other behaviour is identical.

Decomposition:
- Shared package lii_pkg: LII_ID_W=8, default PW, and the state enum typedef (IDLE, GRANT).
- One combinational sub-module, rr_pick:
  - Inputs: NREQ request vector, ptr.
  - Outputs: one-hot grant plus index, and any_req.
  - Reusable for the input-side demux scheduler.

Test Plan:
- Reset: hold arstn=0 with req_tvalid=2'b11 → req_tready=0, lii_out_p0_tvalid=0, busy=0. Deassert reset; the first output beat appears 2 cycles after IDLE samples the requests.
- Single requester: req1 sends 5 beats 0x10..0x14, dst=8'h03, tready=1 → lii_out shows 0x10..0x14 on consecutive cycles with src=SRC_ID, dst=8'h03, first beat 2 cycles after req_tvalid.
- Fair rotation: MAX_BURST=4, both requesters continuously valid → output pattern is 4 beats req0, 1 bubble, 4 beats req1, repeating; no requester starves.
- Backpressure: drop lii_out_p0_tready for 3 cycles mid-burst → tdata and dst stay stable, req_tready[g]=0 during the stall, no beat lost or duplicated, burst still ends after exactly MAX_BURST beats.
- Early release: req0 drops valid after 2 beats while req1 is valid → IDLE, then grant to req1; ptr=1; req1 beats follow after one bubble.
- Async reset mid-burst: assert arstn low in a cycle with lii_out_p0_tvalid=1 → outputs zero immediately without a clock edge; after release, state=IDLE and ptr=0, so req0 wins a tie.
